// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch FSM with a one-word hold buffer.
// Optional feature macro FETCH_MISALIGN_CHECK_EN: a misaligned redirect raises sticky fetch_fault.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        ce,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        fetch_fault
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_FAULT
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] ipc_q, ipc_d;
   logic        ce_q, ce_d;
   logic        kill_q, kill_d;
   logic [31:0] redir_tgt;
   logic        redir_bad;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign redir_tgt = redirect_pc;
   assign redir_bad = |redirect_pc[1:0];
`else
   logic unused_redir_lsb;
   assign unused_redir_lsb = ^redirect_pc[1:0];
   assign redir_tgt        = {redirect_pc[31:2], 2'b00};
   assign redir_bad        = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_REQ;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         instr_q <= NOP;
         ipc_q   <= RESET_PC;
         ce_q    <= 1'b0;
         kill_q  <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         ce_q    <= ce_d;
         kill_q  <= kill_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      ce_d    = 1'b0;
      kill_d  = kill_q;
      if (state_q == S_FAULT) begin
         state_d = S_FAULT;
      end else if (redirect) begin
         if (redir_bad) begin
            state_d = S_FAULT;
            kill_d  = 1'b0;
         end else begin
            pc_d = redir_tgt;
            // A response coinciding with the redirect closes the transaction, so no kill is left armed.
            case (state_q)
               S_WAIT: begin
                  if (imem_rvalid) begin
                     state_d = S_REQ;
                     kill_d  = 1'b0;
                  end else begin
                     state_d = S_WAIT;
                     kill_d  = 1'b1;
                  end
               end
               S_REQ: begin
                  if (imem_ready) begin
                     state_d = S_WAIT;
                     kill_d  = 1'b1;
                  end else begin
                     state_d = S_REQ;
                  end
               end
               default: state_d = S_REQ;
            endcase
         end
      end else begin
         case (state_q)
            S_REQ: begin
               if (imem_ready) begin
                  state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  if (kill_q) begin
                     kill_d  = 1'b0;
                     state_d = S_REQ;
                  end else begin
                     instr_d = imem_rdata;
                     ipc_d   = pc_q;
                     pc_d    = pc_q + 32'd4;
                     if (stall) begin
                        state_d = S_HOLD;
                     end else begin
                        ce_d    = 1'b1;
                        state_d = S_REQ;
                     end
                  end
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  ce_d    = 1'b1;
                  state_d = S_REQ;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      imem_req  = (state_q == S_REQ) && !rst;
      imem_addr = pc_q;
      instr     = instr_q;
      instr_pc  = ipc_q;
      ce        = ce_q;
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   logic fault_q;

   // FAULT is only left through reset, so tracking the state keeps the flag sticky.
   always_ff @(posedge clk) begin
      if (rst) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= (state_d == S_FAULT);
      end
   end

   assign fetch_fault = fault_q;
`else
   assign fetch_fault = 1'b0;
`endif

endmodule
